// File: rtl/spmm_host_link.sv
//============================================================================
// Module   : spmm_host_link
// Brief    : Host-side partner of the SpMM core. Streams a locally held dense
//            N x N RHS matrix out as four-row beats, then collects the N x N
//            result as four-row beats and exposes it through a registered
//            row-read port.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module spmm_host_link #(
    parameter int N = 16,
    parameter int W = 8,
    localparam int LGN   = $clog2(N),
    localparam int BEATS = N / 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [LGN-1:0]       wr_row,
    input  logic [N*W-1:0]       wr_data,
    input  logic                 cmd_go,
    input  logic                 cmd_skip_rhs,
    output logic                 busy,
    output logic                 done,
    input  logic                 rhs_ready,
    output logic                 rhs_start,
    output logic [4*N*W-1:0]     rhs_data,
    input  logic                 out_ready,
    output logic                 out_start,
    input  logic [4*N*W-1:0]     out_data,
    input  logic [LGN-1:0]       res_rd_row,
    output logic [N*W-1:0]       res_rd_data
);

    localparam int CW = (LGN > 2) ? LGN - 2 : 1;
    localparam int RW = N * W;

    localparam logic [CW-1:0] c_LAST_BEAT = CW'(BEATS - 1);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_WAIT_RHS = 3'd1;
    localparam logic [2:0] c_ST_SEND_RHS = 3'd2;
    localparam logic [2:0] c_ST_WAIT_OUT = 3'd3;
    localparam logic [2:0] c_ST_RECV_OUT = 3'd4;
    localparam logic [2:0] c_ST_DONE     = 3'd5;

    logic [2:0]       r_state;
    logic [CW-1:0]    r_beat;
    logic [RW-1:0]    r_rhs_buf [N];
    logic [RW-1:0]    r_res_buf [N];

    logic [CW-1:0]    w_send_beat;
    logic [LGN-1:0]   w_send_base;
    logic [4*RW-1:0]  w_send_rows;

    // The beat loaded into rhs_data at the next edge: beat 0 when entering
    // SEND_RHS, otherwise the one after the beat currently on the bus.
    assign w_send_beat = (r_state == c_ST_WAIT_RHS) ? '0 : r_beat + CW'(1);

    if (LGN > 2) begin : g_base_wide
        assign w_send_base = {w_send_beat, 2'b00};
    end else begin : g_base_narrow
        assign w_send_base = '0;
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_send_row
        assign w_send_rows[gi*RW +: RW] = r_rhs_buf[w_send_base | LGN'(gi)];
    end

    for (genvar gr = 0; gr < N; gr++) begin : g_row
        localparam logic [CW-1:0] c_ROW_BEAT = CW'(gr / 4);
        localparam int            c_LANE     = gr % 4;

        // Host writes land only while idle, so the RHS in flight never changes.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_rhs_buf[gr] <= '0;
            end else if (wr_en && !busy && (wr_row == LGN'(gr))) begin
                r_rhs_buf[gr] <= wr_data;
            end
        end

        // Capture this row from its lane of the matching result beat.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_res_buf[gr] <= '0;
            end else if ((r_state == c_ST_RECV_OUT) && (r_beat == c_ROW_BEAT)) begin
                r_res_buf[gr] <= out_data[c_LANE*RW +: RW];
            end
        end
    end

    // Transfer sequencer; every output is registered and aligned with the state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= c_ST_IDLE;
            r_beat      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rhs_start   <= 1'b0;
            rhs_data    <= '0;
            out_start   <= 1'b0;
            res_rd_data <= '0;
        end else begin
            done        <= 1'b0;
            rhs_start   <= 1'b0;
            out_start   <= 1'b0;
            res_rd_data <= r_res_buf[res_rd_row];
            case (r_state)
                c_ST_IDLE: begin
                    if (cmd_go) begin
                        r_state <= cmd_skip_rhs ? c_ST_WAIT_OUT : c_ST_WAIT_RHS;
                        busy    <= 1'b1;
                    end
                end
                c_ST_WAIT_RHS: begin
                    if (rhs_ready) begin
                        r_state   <= c_ST_SEND_RHS;
                        r_beat    <= '0;
                        rhs_start <= 1'b1;
                        rhs_data  <= w_send_rows;
                    end
                end
                c_ST_SEND_RHS: begin
                    if (r_beat == c_LAST_BEAT) begin
                        r_state  <= c_ST_WAIT_OUT;
                        rhs_data <= '0;
                    end else begin
                        r_beat   <= r_beat + CW'(1);
                        rhs_data <= w_send_rows;
                    end
                end
                c_ST_WAIT_OUT: begin
                    if (out_ready) begin
                        r_state   <= c_ST_RECV_OUT;
                        r_beat    <= '0;
                        out_start <= 1'b1;
                    end
                end
                c_ST_RECV_OUT: begin
                    if (r_beat == c_LAST_BEAT) begin
                        r_state <= c_ST_DONE;
                        done    <= 1'b1;
                    end else begin
                        r_beat  <= r_beat + CW'(1);
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state  <= c_ST_IDLE;
                    busy     <= 1'b0;
                    rhs_data <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spmm_host_link.sv
//============================================================================
// Module   : tb_spmm_host_link
// Brief    : Self-checking bench for spmm_host_link.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_spmm_host_link;

    localparam int N     = 16;
    localparam int W     = 8;
    localparam int BEATS = N / 4;
    localparam int LGN   = 4;
    localparam int RW    = N * W;
    localparam int BW    = 4 * RW;
    localparam int NV    = 16;
    localparam bit H     = 1'b1;
    localparam bit L     = 1'b0;

    typedef struct {
        bit go;
        bit skip;
        bit rr;
        bit orr;
        bit e_busy;
        bit e_done;
        bit e_rs;
        bit e_os;
        int e_rbeat;
        int out_beat;
    } vec_t;

    logic            clock        = 1'b0;
    logic            reset        = 1'b0;
    logic            wr_en        = 1'b0;
    logic [LGN-1:0]  wr_row       = '0;
    logic [RW-1:0]   wr_data      = '0;
    logic            cmd_go       = 1'b0;
    logic            cmd_skip_rhs = 1'b0;
    logic            rhs_ready    = 1'b0;
    logic            out_ready    = 1'b0;
    logic [BW-1:0]   out_data     = '0;
    logic [LGN-1:0]  res_rd_row   = '0;
    logic            busy;
    logic            done;
    logic            rhs_start;
    logic            out_start;
    logic [BW-1:0]   rhs_data;
    logic [RW-1:0]   res_rd_data;

    vec_t            tbl [NV];
    logic [W-1:0]    m_rhs [N][N];
    logic [W-1:0]    m_res [N][N];
    int              errors = 0;
    int              checks = 0;
    int              n_rhs_start = 0;
    int              n_done = 0;

    spmm_host_link #(.N(N), .W(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_row       (wr_row),
        .wr_data      (wr_data),
        .cmd_go       (cmd_go),
        .cmd_skip_rhs (cmd_skip_rhs),
        .busy         (busy),
        .done         (done),
        .rhs_ready    (rhs_ready),
        .rhs_start    (rhs_start),
        .rhs_data     (rhs_data),
        .out_ready    (out_ready),
        .out_start    (out_start),
        .out_data     (out_data),
        .res_rd_row   (res_rd_row),
        .res_rd_data  (res_rd_data)
    );

    always #5 clock = ~clock;

    // Pulse counters used to detect missing or extra transfers.
    always @(negedge clock) begin
        if (rhs_start) n_rhs_start++;
        if (done)      n_done++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach its end");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_bit(input string nm, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", nm, act, req);
        end
    endtask

    task automatic chk_row(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic chk_vec(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    function automatic vec_t mk(input bit go, input bit skip, input bit rr, input bit orr,
                                input bit b, input bit d, input bit rs, input bit os,
                                input int rb, input int ob);
        vec_t v;
        v.go = go; v.skip = skip; v.rr = rr; v.orr = orr;
        v.e_busy = b; v.e_done = d; v.e_rs = rs; v.e_os = os;
        v.e_rbeat = rb; v.out_beat = ob;
        return v;
    endfunction

    function automatic logic [RW-1:0] rand_row();
        logic [RW-1:0] v;
        for (int j = 0; j < RW / 32; j++) v[j*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [BW-1:0] rand_beat();
        logic [BW-1:0] v;
        for (int j = 0; j < BW / 32; j++) v[j*32 +: 32] = $urandom;
        return v;
    endfunction

    // Expected RHS beat k: matrix rows 4k..4k+3, row i in lane i.
    function automatic logic [BW-1:0] exp_beat(input int k);
        logic [BW-1:0] v;
        for (int i = 0; i < 4; i++)
            for (int c = 0; c < N; c++)
                v[(i*N+c)*W +: W] = m_rhs[4*k+i][c];
        return v;
    endfunction

    function automatic logic [RW-1:0] exp_row(input int r);
        logic [RW-1:0] v;
        for (int c = 0; c < N; c++) v[c*W +: W] = m_res[r][c];
        return v;
    endfunction

    // Directed result beat k: every element of lane i equals 100+4k+i.
    function automatic logic [BW-1:0] tbl_out(input int k);
        logic [BW-1:0] v;
        for (int i = 0; i < 4; i++)
            for (int c = 0; c < N; c++)
                v[(i*N+c)*W +: W] = W'(100 + 4*k + i);
        return v;
    endfunction

    task automatic capture(input int k, input logic [BW-1:0] d);
        for (int i = 0; i < 4; i++)
            for (int c = 0; c < N; c++)
                m_res[4*k+i][c] = d[(i*N+c)*W +: W];
    endtask

    task automatic clear_model();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                m_rhs[r][c] = '0;
                m_res[r][c] = '0;
            end
    endtask

    // Host write while idle: the buffer row takes the data at the next edge.
    task automatic set_wr(input int r, input logic [RW-1:0] d);
        wr_en   = 1'b1;
        wr_row  = LGN'(r);
        wr_data = d;
        for (int c = 0; c < N; c++) m_rhs[r][c] = d[c*W +: W];
    endtask

    // Writes and commands issued while busy; all of them must be dropped.
    task automatic ignored_junk();
        wr_en   = 1'b1;
        wr_row  = LGN'($urandom);
        wr_data = rand_row();
        cmd_go  = 1'($urandom);
    endtask

    task automatic clear_junk();
        wr_en  = 1'b0;
        cmd_go = 1'b0;
    endtask

    task automatic read_all();
        for (int r = 0; r < N; r++) begin
            res_rd_row = LGN'(r);
            tick();
            chk_row($sformatf("res_row%0d", r), res_rd_data, exp_row(r));
        end
    endtask

    // One complete transfer with random handshake timing and random data.
    task automatic run_txn(input bit skip);
        int            s0;
        int            d0;
        int            nw;
        bit            seen;
        logic [BW-1:0] d;
        s0 = n_rhs_start;
        d0 = n_done;
        nw = $urandom_range(0, 3);
        for (int j = 0; j < nw; j++) begin
            set_wr($urandom_range(0, N-1), rand_row());
            tick();
        end
        set_wr($urandom_range(0, N-1), rand_row());
        cmd_go       = 1'b1;
        cmd_skip_rhs = skip;
        rhs_ready    = skip;
        tick();
        wr_en        = 1'b0;
        cmd_go       = 1'b0;
        cmd_skip_rhs = 1'b0;
        chk_bit("txn_busy", busy, 1'b1);
        if (!skip) begin
            nw = $urandom_range(0, 3);
            for (int j = 0; j < nw; j++) begin
                chk_vec("wait_rhs_data", rhs_data, '0);
                ignored_junk();
                tick();
            end
            clear_junk();
            rhs_ready = 1'b1;
            seen = 1'b0;
            for (int t = 0; t < 10 && !seen; t++) begin
                tick();
                seen = rhs_start;
            end
            chk_bit("rhs_start_seen", seen, 1'b1);
            for (int k = 0; k < BEATS; k++) begin
                chk_bit($sformatf("rhs_start_beat%0d", k), rhs_start, k == 0);
                chk_vec($sformatf("rhs_data_beat%0d", k), rhs_data, exp_beat(k));
                rhs_ready = 1'($urandom);
                tick();
            end
            rhs_ready = 1'b0;
            chk_vec("rhs_data_after_send", rhs_data, '0);
        end
        nw = $urandom_range(0, 3);
        for (int j = 0; j < nw; j++) begin
            ignored_junk();
            tick();
        end
        clear_junk();
        out_ready = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            tick();
            seen = out_start;
        end
        chk_bit("out_start_seen", seen, 1'b1);
        for (int k = 0; k < BEATS; k++) begin
            chk_bit($sformatf("out_start_beat%0d", k), out_start, k == 0);
            d = rand_beat();
            out_data = d;
            capture(k, d);
            if (k == 1) begin
                wr_en   = 1'b1;
                wr_row  = LGN'(5);
                wr_data = '1;
                cmd_go  = 1'b1;
            end
            out_ready = 1'($urandom);
            tick();
            clear_junk();
        end
        out_ready = 1'b0;
        rhs_ready = 1'b0;
        out_data  = rand_beat();
        chk_bit("done_pulse", done, 1'b1);
        chk_bit("busy_in_done", busy, 1'b1);
        tick();
        chk_bit("done_falls", done, 1'b0);
        chk_bit("busy_falls", busy, 1'b0);
        tick();
        chk_bit("busy_stays_low", busy, 1'b0);
        chk_int("rhs_start_count", n_rhs_start - s0, skip ? 0 : 1);
        chk_int("done_count", n_done - d0, 1);
        read_all();
    endtask

    initial begin
        int            d0;
        bit            seen;
        logic [RW-1:0] row;

        clear_model();

        // Reset held for three cycles under random inputs.
        reset = 1'b0;
        for (int j = 0; j < 3; j++) begin
            wr_en        = 1'($urandom);
            wr_row       = LGN'($urandom);
            wr_data      = rand_row();
            cmd_go       = 1'($urandom);
            cmd_skip_rhs = 1'($urandom);
            rhs_ready    = 1'($urandom);
            out_ready    = 1'($urandom);
            out_data     = rand_beat();
            res_rd_row   = LGN'($urandom);
            tick();
            chk_bit("rst_busy", busy, 1'b0);
            chk_bit("rst_done", done, 1'b0);
            chk_bit("rst_rhs_start", rhs_start, 1'b0);
            chk_bit("rst_out_start", out_start, 1'b0);
            chk_vec("rst_rhs_data", rhs_data, '0);
            chk_row("rst_res_rd_data", res_rd_data, '0);
        end
        wr_en = 1'b0; cmd_go = 1'b0; cmd_skip_rhs = 1'b0;
        rhs_ready = 1'b0; out_ready = 1'b0; out_data = '0;
        reset = 1'b1;
        tick();
        chk_bit("post_rst_busy", busy, 1'b0);
        read_all();

        // Directed transfer: RHS[r][c] = (16r+c) % 256, results 100+r.
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) row[c*W +: W] = W'((16*r + c) % 256);
            set_wr(r, row);
            tick();
        end
        wr_en = 1'b0;

        tbl[0]  = mk(H, L, H, L,  L, L, L, L, -1, -1);
        tbl[1]  = mk(L, L, H, L,  H, L, L, L, -1, -1);
        tbl[2]  = mk(L, L, H, L,  H, L, H, L,  0, -1);
        tbl[3]  = mk(L, L, H, L,  H, L, L, L,  1, -1);
        tbl[4]  = mk(L, L, L, L,  H, L, L, L,  2, -1);
        tbl[5]  = mk(L, L, L, L,  H, L, L, L,  3, -1);
        tbl[6]  = mk(L, L, L, L,  H, L, L, L, -1, -1);
        tbl[7]  = mk(L, L, L, H,  H, L, L, L, -1, -1);
        tbl[8]  = mk(L, L, L, H,  H, L, L, H, -1,  0);
        tbl[9]  = mk(L, L, L, H,  H, L, L, L, -1,  1);
        tbl[10] = mk(L, L, L, L,  H, L, L, L, -1,  2);
        tbl[11] = mk(L, L, L, L,  H, L, L, L, -1,  3);
        tbl[12] = mk(L, L, H, H,  H, H, L, L, -1, -1);
        tbl[13] = mk(L, L, H, H,  L, L, L, L, -1, -1);
        tbl[14] = mk(L, L, L, L,  L, L, L, L, -1, -1);
        tbl[15] = mk(L, L, L, L,  L, L, L, L, -1, -1);

        for (int j = 0; j < NV; j++) begin
            chk_bit($sformatf("vec%0d_busy", j), busy, tbl[j].e_busy);
            chk_bit($sformatf("vec%0d_done", j), done, tbl[j].e_done);
            chk_bit($sformatf("vec%0d_rhs_start", j), rhs_start, tbl[j].e_rs);
            chk_bit($sformatf("vec%0d_out_start", j), out_start, tbl[j].e_os);
            chk_vec($sformatf("vec%0d_rhs_data", j), rhs_data,
                    (tbl[j].e_rbeat < 0) ? '0 : exp_beat(tbl[j].e_rbeat));
            cmd_go       = tbl[j].go;
            cmd_skip_rhs = tbl[j].skip;
            rhs_ready    = tbl[j].rr;
            out_ready    = tbl[j].orr;
            if (tbl[j].out_beat >= 0) begin
                out_data = tbl_out(tbl[j].out_beat);
                capture(tbl[j].out_beat, out_data);
            end else begin
                out_data = rand_beat();
            end
            tick();
        end
        cmd_go = 1'b0; rhs_ready = 1'b0; out_ready = 1'b0;
        read_all();

        // Weight reuse with rhs_ready held high, then a normal transfer.
        run_txn(1'b1);
        run_txn(1'b0);

        // Reset in the middle of the RHS stream, at beat 2.
        set_wr(0, rand_row());
        tick();
        set_wr(9, rand_row());
        tick();
        wr_en     = 1'b0;
        cmd_go    = 1'b1;
        rhs_ready = 1'b1;
        tick();
        cmd_go = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            tick();
            seen = rhs_start;
        end
        chk_bit("abort_rhs_start_seen", seen, 1'b1);
        tick();
        tick();
        chk_vec("abort_beat2_before", rhs_data, exp_beat(2));
        d0 = n_done;
        #2;
        reset = 1'b0;
        #1;
        chk_bit("abort_rhs_start", rhs_start, 1'b0);
        chk_vec("abort_rhs_data", rhs_data, '0);
        chk_bit("abort_busy", busy, 1'b0);
        clear_model();
        rhs_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk_bit("abort_idle_busy", busy, 1'b0);
        end
        chk_int("abort_no_done", n_done - d0, 0);

        // Randomised transfers after the abort.
        for (int j = 0; j < 12; j++) run_txn(1'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
